// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN spike classifier.
// Holds the FSM state enum, the window reset value and the saturating increment.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int WIN_LEN_RESET = 16;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] maxv
  );
    return (v >= maxv) ? maxv : v + 32'd1;
  endfunction

endpackage

// File: rtl/snn_sat_counter.sv
// Saturating per-neuron spike counter with synchronous clear.
// Ports: clk, reset, clear, inc -> count (holds at 2^W-1).
module snn_sat_counter
  import snn_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAXV = '1;

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (inc)
      count <= W'(sat_inc(32'(count), 32'(MAXV)));
  end

endmodule

// File: rtl/snn_spike_classifier.sv
// Rate-decoding classifier: counts last-layer spikes over a window, then
// scans for the busiest neuron and offers {class, count, none} via valid/ready.
// Ports: clk, reset (sync, active-high), cfg_we/cfg_win, start, step_valid,
// spikes -> busy; out_valid/out_ready, out_class, out_count, out_none.
// Optional SNN_CLASSIFIER_READOUT_EN adds rd_idx/rd_count counter readout.
module snn_spike_classifier
  import snn_pkg::*;
#(
  parameter int NEURONS  = 8,
  parameter int CNT_BITS = 6,
  parameter int WIN_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [WIN_BITS-1:0]        cfg_win,
  input  logic                       start,
  input  logic                       step_valid,
  input  logic [NEURONS-1:0]         spikes,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NEURONS)-1:0] out_class,
  output logic [CNT_BITS-1:0]        out_count,
`ifdef SNN_CLASSIFIER_READOUT_EN
  input  logic [$clog2(NEURONS)-1:0] rd_idx,
  output logic [CNT_BITS-1:0]        rd_count,
`endif
  output logic                       out_none
);

  localparam int IW = $clog2(NEURONS);
  localparam int SW = $clog2(NEURONS + 1);

  state_t state, state_nx;

  logic [WIN_BITS-1:0] win_len;
  logic [WIN_BITS-1:0] step_cnt;
  logic [WIN_BITS-1:0] win_eff;
  logic [WIN_BITS-1:0] step_inc;
  logic                step_last;

  logic [SW-1:0]       scan_idx;
  logic                scan_end;
  logic [IW-1:0]       best_idx;
  logic [CNT_BITS-1:0] best_cnt;
  logic [CNT_BITS-1:0] cur_cnt;

  logic [CNT_BITS-1:0] cnt [NEURONS];
  logic                cnt_clr;

  // A zero-length window still consumes one step.
  assign win_eff   = (win_len == '0) ? WIN_BITS'(1) : win_len;
  assign step_inc  = step_cnt + WIN_BITS'(1);
  assign step_last = (step_inc == win_eff);

  // One extra ARGMAX cycle after the last neuron latches the result.
  assign scan_end = (scan_idx == SW'(NEURONS));
  assign cur_cnt  = cnt[scan_idx[IW-1:0]];

  assign cnt_clr = (state == IDLE) && start;

  for (genvar i = 0; i < NEURONS; i++) begin : g_cnt
    snn_sat_counter #(
      .W(CNT_BITS)
    ) u_cnt (
      .clk  (clk),
      .reset(reset),
      .clear(cnt_clr),
      .inc  ((state == ACCUM) && step_valid && spikes[i]),
      .count(cnt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start) state_nx = ACCUM;
      ACCUM:  if (step_valid && step_last) state_nx = ARGMAX;
      ARGMAX: if (scan_end) state_nx = DONE;
      DONE:   if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = (state == ACCUM) || (state == ARGMAX);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      win_len   <= WIN_BITS'(WIN_LEN_RESET);
      step_cnt  <= '0;
      scan_idx  <= '0;
      best_idx  <= '0;
      best_cnt  <= '0;
      out_class <= '0;
      out_count <= '0;
      out_none  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_we)
            win_len <= cfg_win;
          if (start) begin
            step_cnt <= '0;
            scan_idx <= '0;
            best_idx <= '0;
            best_cnt <= '0;
          end
        end
        ACCUM: begin
          if (step_valid)
            step_cnt <= step_inc;
        end
        ARGMAX: begin
          if (!scan_end) begin
            if (cur_cnt > best_cnt) begin
              best_cnt <= cur_cnt;
              best_idx <= scan_idx[IW-1:0];
            end
            scan_idx <= scan_idx + SW'(1);
          end else begin
            out_class <= (best_cnt == '0) ? '0 : best_idx;
            out_count <= best_cnt;
            out_none  <= (best_cnt == '0);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SNN_CLASSIFIER_READOUT_EN
  always_ff @(posedge clk) begin
    if (reset)
      rd_count <= '0;
    else
      rd_count <= cnt[rd_idx];
  end
`endif

endmodule

// File: tb/tb_snn_spike_classifier.sv
// Directed self-checking bench for snn_spike_classifier.
// Drives windows with hand-computed winners and checks latency and handshake.
module tb_snn_spike_classifier;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [7:0] cfg_win;
  logic       start;
  logic       step_valid;
  logic [7:0] spikes;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_class;
  logic [5:0] out_count;
  logic       out_none;
`ifdef SNN_CLASSIFIER_READOUT_EN
  logic [2:0] rd_idx = '0;
  logic [5:0] rd_count;
`endif

  int total = 0;
  int bad   = 0;
  int lat;

  always #5 clk = ~clk;

  snn_spike_classifier dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_win   (cfg_win),
    .start     (start),
    .step_valid(step_valid),
    .spikes    (spikes),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_count (out_count),
`ifdef SNN_CLASSIFIER_READOUT_EN
    .rd_idx    (rd_idx),
    .rd_count  (rd_count),
`endif
    .out_none  (out_none)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(
    input  bit         do_cfg,
    input  logic [7:0] win,
    input  logic [7:0] spk,
    input  int         nsteps,
    output int         l
  );
    if (do_cfg) begin
      cfg_we  = 1'b1;
      cfg_win = win;
      tick();
      cfg_we  = 1'b0;
    end
    start = 1'b1;
    tick();
    start      = 1'b0;
    step_valid = 1'b1;
    spikes     = spk;
    repeat (nsteps) tick();
    step_valid = 1'b0;
    spikes     = '0;
    l = 0;
    while (!out_valid && l < 400) begin
      tick();
      l++;
    end
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, int'(out_valid), 0);
    check({tag, "_busy_idle"}, int'(busy), 0);
  endtask

  initial begin
    reset      = 1'b1;
    cfg_we     = 1'b0;
    cfg_win    = '0;
    start      = 1'b0;
    step_valid = 1'b0;
    spikes     = '0;
    out_ready  = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_class", int'(out_class), 0);
    check("rst_count", int'(out_count), 0);
    check("rst_none", int'(out_none), 0);

    // single winner, window 4
    run(1'b1, 8'd4, 8'b0000_0100, 4, lat);
    check("t1_lat", lat, 9);
    check("t1_class", int'(out_class), 2);
    check("t1_count", int'(out_count), 4);
    check("t1_none", int'(out_none), 0);
    accept("t1");

    // tie between 1 and 5 -> lowest index
    run(1'b1, 8'd3, 8'b0010_0010, 3, lat);
    check("t2_lat", lat, 9);
    check("t2_class", int'(out_class), 1);
    check("t2_count", int'(out_count), 3);
    accept("t2");

    // saturation at 63
    run(1'b1, 8'd100, 8'b1000_0000, 100, lat);
    check("t3_lat", lat, 9);
    check("t3_class", int'(out_class), 7);
    check("t3_count", int'(out_count), 63);
    accept("t3");

    // silent window, held result, ignored starts
    run(1'b1, 8'd5, 8'h00, 5, lat);
    check("t4_lat", lat, 9);
    check("t4_none", int'(out_none), 1);
    check("t4_class", int'(out_class), 0);
    check("t4_count", int'(out_count), 0);
    for (int i = 0; i < 10; i++) begin
      start = (i % 3 == 0);
      tick();
    end
    start = 1'b0;
    check("t4_hold_valid", int'(out_valid), 1);
    check("t4_hold_none", int'(out_none), 1);
    check("t4_hold_busy", int'(busy), 0);
    accept("t4");
    check("t4_retain_none", int'(out_none), 1);

    // zero window behaves as one step
    run(1'b1, 8'd0, 8'b0000_0001, 1, lat);
    check("t5_lat", lat, 9);
    check("t5_class", int'(out_class), 0);
    check("t5_count", int'(out_count), 1);
    accept("t5");

    // cfg_we during ACCUM must not stretch the window
    cfg_we  = 1'b1;
    cfg_win = 8'd2;
    tick();
    cfg_we = 1'b0;
    start  = 1'b1;
    tick();
    start      = 1'b0;
    cfg_we     = 1'b1;
    cfg_win    = 8'd50;
    step_valid = 1'b1;
    spikes     = 8'b0000_1000;
    repeat (2) tick();
    cfg_we     = 1'b0;
    step_valid = 1'b0;
    spikes     = '0;
    lat = 0;
    while (!out_valid && lat < 400) begin
      tick();
      lat++;
    end
    check("t6_lat", lat, 9);
    check("t6_class", int'(out_class), 3);
    check("t6_count", int'(out_count), 2);
    accept("t6");

    // reset during ARGMAX, then fresh run with default window 16
    run(1'b1, 8'd4, 8'b0001_0000, 0, lat);
    step_valid = 1'b1;
    spikes     = 8'b0001_0000;
    repeat (4) tick();
    step_valid = 1'b0;
    spikes     = '0;
    repeat (3) tick();
    check("t7_busy_argmax", int'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t7_busy_rst", int'(busy), 0);
    check("t7_valid_rst", int'(out_valid), 0);
    check("t7_class_rst", int'(out_class), 0);
    run(1'b0, 8'd0, 8'b0100_0000, 16, lat);
    check("t7_lat", lat, 9);
    check("t7_class", int'(out_class), 6);
    check("t7_count", int'(out_count), 16);
    accept("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
